image_mem_arbiter: RTL and testbench
====================================

Name: image_mem_arbiter

Overview:
- Two-port Avalon-MM arbiter for the dual-processor image pipeline. Lets both processor data masters share one single-port 32-bit on-chip RAM: 10000 words, 14-bit word address, byte enables, 1-cycle read latency, unregistered q.
- Sits between the two processor data masters and the RAM's clocked port.
- Round-robin arbitration, lock support for atomic sequences, out-of-range address protection.

Parameters:
- ADDR_W, 14, word-address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- DEPTH, 10000, number of valid words; addresses >= DEPTH are out of range
- OOR_CNT_W, 16, width of the out-of-range event counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sN_address  in  ADDR_W  word address, port N (N = 0, 1; applies to all sN_ lines below)
- sN_byteenable  in  BE_W  byte lanes
- sN_read  in  1  read request
- sN_write  in  1  write request
- sN_writedata  in  DATA_W  write data
- sN_lock  in  1  hold the grant after this transfer
- sN_waitrequest  out  1  transfer not accepted this cycle
- sN_readdata  out  DATA_W  read data
- sN_readdatavalid  out  1  sN_readdata valid
- m_address  out  ADDR_W  RAM address
- m_byteenable  out  BE_W  RAM byte enables
- m_chipselect  out  1  RAM select
- m_write  out  1  RAM write (write = chipselect & write at RAM)
- m_writedata  out  DATA_W  RAM write data
- m_clken  out  1  RAM clock enable
- m_readdata  in  DATA_W  RAM q, valid 1 cycle after a read address is presented
- oor_count  out  OOR_CNT_W  saturating count of out-of-range accesses

Behaviour:
- Request: reqN = sN_read | sN_write. sN_read & sN_write together is illegal; treat it as a write and assert a sim-only error.
- FSM states:
  - ARB: grant to the sole requester. If both request, grant the port that is not last_grant.
  - LOCK0/LOCK1: only the locking port may be granted; the other waits.
  - ARB -> LOCKn: granted transfer on port n has sN_lock=1.
  - LOCKn -> ARB: on the first accepted transfer from port n with sN_lock=0.
  - LOCKn stays put while port n is idle.
- last_grant (1 bit): updated to the granted port on every accepted transfer.
- Accept: granted port sees sN_waitrequest=0 in the same cycle. The non-granted requester sees 1. A non-requesting port sees 0.
- Throughput: one transfer per cycle. Back-to-back grants are allowed; reads may be pipelined.
- Master side (combinational from the granted port):
  - m_address, m_byteenable, m_writedata passed through.
  - m_chipselect = 1 on an accepted in-range transfer.
  - m_write = accepted in-range write.
  - Idle: m_chipselect=0, m_write=0, m_address/m_writedata hold the last value.
- m_clken = 1 whenever reset_n=1.
- Read return pipeline:
  - On an accepted read, register rd_pend=1, rd_owner=n, rd_oor.
  - Next cycle: sN_readdatavalid=1 for rd_owner only; sN_readdata = m_readdata, or 32'h0 if rd_oor.
  - Fixed latency 1 cycle from acceptance. sN_readdata is don't-care when not valid, but is driven to the same bus.
- Out of range (address >= DEPTH):
  - Transfer is accepted, m_chipselect stays 0.
  - Write dropped; read returns 0 with normal valid timing.
  - oor_count increments and saturates at all-ones.
- Reset (asynchronous, reset_n=0): state=ARB, last_grant=1 (so port 0 wins the first tie), rd_pend=0, oor_count=0, all sN_waitrequest=1, sN_readdatavalid=0, sN_readdata=0, m_chipselect=0, m_write=0, m_clken=0, m_address=0.
- Reset mid-operation: any pending readdatavalid is dropped and the lock is released.
- Simultaneous events:
  - A read return to port x and a new grant to port y in the same cycle are independent.
  - Lock release and a waiting request from the other port: the other port is granted the next cycle at the earliest.

Decomposition:
- Shared package image_pp_pkg: ADDR_W/DATA_W/BE_W/DEPTH constants and the FSM state enum (ARB, LOCK0, LOCK1).
- One natural sub-module: rr_arb2, a 2-way round-robin grant with last_grant register and hold input, reusable for future shared peripherals.
- Read-return and OOR counter logic stay inline.

Test Plan:
- Port 0 writes 32'hCAFEBABE to addr 5 with byteenable 4'hF; port 1 idle -> waitrequest0=0 same cycle, m_write=1, m_address=5. Port 1 then reads addr 5 -> readdatavalid1=1 one cycle later with 32'hCAFEBABE.
- Both ports read continuously after reset -> grants alternate 0,1,0,1. Each port sees waitrequest high on alternate cycles; readdatavalid goes only to the issuing port.
- Port 1 sets lock for reads at addrs 10, 11; port 0 requests throughout -> port 0 held off until port 1's unlocked transfer at addr 11 is accepted. Port 0 is granted the following cycle.
- Port 0 writes addr 10000, then reads addr 16383 -> m_chipselect=0 both cycles, read returns 32'h0 with readdatavalid, oor_count=2.
- Port 0 writes 32'h11223344 with byteenable 4'b0101 over an existing 32'hFFFFFFFF -> readback 32'hFF22FF44.
- Read accepted, then reset_n pulsed low before the return cycle -> no readdatavalid, all outputs at reset values, oor_count=0. After release, port 0 wins the first tie.

Source files
------------

// File: rtl/image_pp_pkg.sv
// Shared constants and arbiter state encoding for the dual-processor image pipeline.
// Memory geometry matches the 10000-word single-port on-chip RAM.
package image_pp_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int DEPTH     = 10000;
  localparam int OOR_CNT_W = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, combinational; hold pins the grant to hold_port.
// A granted request is accepted the same cycle, so last_grant follows every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       hold,
  input  logic       hold_port,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (hold) begin
      gnt[hold_port] = req[hold_port];
    end else if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Reset to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/image_mem_arbiter.sv
// Two Avalon-MM slaves sharing one single-port RAM: round-robin, lock, out-of-range guard.
// Grant and accept are same-cycle; read data returns exactly one cycle after acceptance.
module image_mem_arbiter #(
  parameter int ADDR_W    = image_pp_pkg::ADDR_W,
  parameter int DATA_W    = image_pp_pkg::DATA_W,
  parameter int BE_W      = image_pp_pkg::BE_W,
  parameter int DEPTH     = image_pp_pkg::DEPTH,
  parameter int OOR_CNT_W = image_pp_pkg::OOR_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    s0_address,
  input  logic [BE_W-1:0]      s0_byteenable,
  input  logic                 s0_read,
  input  logic                 s0_write,
  input  logic [DATA_W-1:0]    s0_writedata,
  input  logic                 s0_lock,
  output logic                 s0_waitrequest,
  output logic [DATA_W-1:0]    s0_readdata,
  output logic                 s0_readdatavalid,
  input  logic [ADDR_W-1:0]    s1_address,
  input  logic [BE_W-1:0]      s1_byteenable,
  input  logic                 s1_read,
  input  logic                 s1_write,
  input  logic [DATA_W-1:0]    s1_writedata,
  input  logic                 s1_lock,
  output logic                 s1_waitrequest,
  output logic [DATA_W-1:0]    s1_readdata,
  output logic                 s1_readdatavalid,
  output logic [ADDR_W-1:0]    m_address,
  output logic [BE_W-1:0]      m_byteenable,
  output logic                 m_chipselect,
  output logic                 m_write,
  output logic [DATA_W-1:0]    m_writedata,
  output logic                 m_clken,
  input  logic [DATA_W-1:0]    m_readdata,
  output logic [OOR_CNT_W-1:0] oor_count
);

  import image_pp_pkg::*;

  arb_state_t        state, state_nxt;
  logic [1:0]        req, gnt, acc;
  logic              any_acc, sel, sel_wr, sel_lock, in_range;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [BE_W-1:0]   sel_be, be_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q, rd_data;
  logic              rd_pend, rd_owner, rd_oor;

  assign req = {s1_read | s1_write, s0_read | s0_write};

  rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .hold      (state != ARB),
    .hold_port (state == LOCK1),
    .gnt       (gnt)
  );

  // Nothing is accepted while reset is asserted, even if a master is requesting.
  assign acc     = gnt & {2{reset_n}};
  assign any_acc = |acc;
  assign sel     = acc[1];

  assign sel_addr  = sel ? s1_address    : s0_address;
  assign sel_be    = sel ? s1_byteenable : s0_byteenable;
  assign sel_wdata = sel ? s1_writedata  : s0_writedata;
  assign sel_wr    = sel ? s1_write      : s0_write;
  assign sel_lock  = sel ? s1_lock       : s0_lock;
  assign in_range  = sel_addr < ADDR_W'(DEPTH);

  assign s0_waitrequest = ~reset_n | (req[0] & ~gnt[0]);
  assign s1_waitrequest = ~reset_n | (req[1] & ~gnt[1]);

  assign m_chipselect = any_acc & in_range;
  assign m_write      = m_chipselect & sel_wr;
  assign m_address    = any_acc ? sel_addr  : addr_q;
  assign m_byteenable = any_acc ? sel_be    : be_q;
  assign m_writedata  = any_acc ? sel_wdata : wdata_q;
  assign m_clken      = reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (any_acc) begin
      addr_q  <= sel_addr;
      be_q    <= sel_be;
      wdata_q <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (any_acc && sel_lock) state_nxt = sel ? LOCK1 : LOCK0;
      LOCK0:   if (acc[0] && !s0_lock) state_nxt = ARB;
      LOCK1:   if (acc[1] && !s1_lock) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // A simultaneous read+write is treated as a write, so only pure reads return data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_oor   <= 1'b0;
    end else begin
      rd_pend <= any_acc & ~sel_wr;
      if (any_acc && !sel_wr) begin
        rd_owner <= sel;
        rd_oor   <= ~in_range;
      end
    end
  end

  assign rd_data          = (rd_pend && !rd_oor) ? m_readdata : '0;
  assign s0_readdata      = rd_data;
  assign s1_readdata      = rd_data;
  assign s0_readdatavalid = rd_pend & ~rd_owner;
  assign s1_readdatavalid = rd_pend &  rd_owner;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_count <= '0;
    end else if (any_acc && !in_range && !(&oor_count)) begin
      oor_count <= oor_count + OOR_CNT_W'(1);
    end
  end

`ifndef SYNTHESIS
  a_s0_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(s0_read && s0_write))
    else $error("s0_read and s0_write asserted together");
  a_s1_rw_excl: assert property (@(posedge clk) disable iff (!reset_n) !(s1_read && s1_write))
    else $error("s1_read and s1_write asserted together");
`endif

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Scripted two-master traffic against a behavioural RAM; a scoreboard checks read returns.
// Expected grants, master-side strobes and oor_count come from the script and a reference memory.
module tb_image_mem_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [13:0] addr;
    logic [3:0]  be;
    logic [31:0] dat;
    logic        lk;
  } req_t;

  typedef struct {
    int          port;
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] s0_address, s1_address, m_address;
  logic [3:0]  s0_byteenable, s1_byteenable, m_byteenable;
  logic        s0_read, s0_write, s0_lock, s1_read, s1_write, s1_lock;
  logic [31:0] s0_writedata, s1_writedata, m_writedata, m_readdata;
  logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic [31:0] s0_readdata, s1_readdata;
  logic        m_chipselect, m_write, m_clken;
  logic [15:0] oor_count;

  image_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_byteenable(s0_byteenable), .s0_read(s0_read),
    .s0_write(s0_write), .s0_writedata(s0_writedata), .s0_lock(s0_lock),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_read(s1_read),
    .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_lock(s1_lock),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken),
    .m_readdata(m_readdata), .oor_count(oor_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Behavioural RAM: registered address, q valid the cycle after a read.
  logic [31:0] ram [16384];
  logic [31:0] ram_q = '0;
  assign m_readdata = ram_q;
  always @(posedge clk) begin
    if (m_clken && m_chipselect) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) ram[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end else begin
        ram_q <= ram[m_address];
      end
    end
  end

  // Reference state.
  logic [31:0] exp_mem [16384];
  int          exp_oor = 0;
  logic [13:0] exp_last_addr = '0;
  bit          skip_push = 1'b0;
  exp_t        sb[$];

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (p == 0 ? s0_readdatavalid : s1_readdatavalid) begin
        if (sb.size() == 0) begin
          chk($sformatf("rdv_spurious_p%0d", p), 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_port", 64'(p), 64'(e.port));
          chk("rd_data", p == 0 ? s0_readdata : s1_readdata, e.dat);
          chk("rd_latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  function automatic req_t idle_q();
    return '0;
  endfunction

  function automatic req_t rd_q(input logic [13:0] a, input logic lk = 1'b0);
    req_t q;
    q = '0; q.rd = 1'b1; q.addr = a; q.be = 4'hF; q.lk = lk;
    return q;
  endfunction

  function automatic req_t wr_q(input logic [13:0] a, input logic [31:0] d,
                                input logic [3:0] be = 4'hF, input logic lk = 1'b0);
    req_t q;
    q = '0; q.wr = 1'b1; q.addr = a; q.dat = d; q.be = be; q.lk = lk;
    return q;
  endfunction

  task automatic drive(input req_t q0, input req_t q1);
    s0_read = q0.rd; s0_write = q0.wr; s0_address = q0.addr;
    s0_byteenable = q0.be; s0_writedata = q0.dat; s0_lock = q0.lk;
    s1_read = q1.rd; s1_write = q1.wr; s1_address = q1.addr;
    s1_byteenable = q1.be; s1_writedata = q1.dat; s1_lock = q1.lk;
  endtask

  // One bus cycle: exp_w = {waitrequest1, waitrequest0} the script expects.
  task automatic step(input string tag, input req_t q0, input req_t q1, input logic [1:0] exp_w);
    req_t aq;
    int   ap;
    logic exp_cs;
    drive(q0, q1);
    ap = -1;
    aq = '0;
    if ((q0.rd || q0.wr) && !exp_w[0]) begin ap = 0; aq = q0; end
    if ((q1.rd || q1.wr) && !exp_w[1]) begin ap = 1; aq = q1; end
    exp_cs = (ap >= 0) && (aq.addr < 14'd10000);
    @(negedge clk);
    chk({tag, "/wait"}, {s1_waitrequest, s0_waitrequest}, exp_w);
    chk({tag, "/cs"}, m_chipselect, exp_cs);
    chk({tag, "/mwr"}, m_write, exp_cs && aq.wr);
    chk({tag, "/addr"}, m_address, (ap >= 0) ? aq.addr : exp_last_addr);
    chk({tag, "/oor"}, oor_count, exp_oor);
    chk({tag, "/clken"}, m_clken, 1'b1);
    if (exp_cs && aq.wr) begin
      chk({tag, "/wdata"}, m_writedata, aq.dat);
      chk({tag, "/be"}, m_byteenable, aq.be);
    end
    if (ap >= 0) begin
      exp_last_addr = aq.addr;
      if (!exp_cs) exp_oor++;
      if (aq.wr) begin
        if (exp_cs)
          for (int b = 0; b < 4; b++)
            if (aq.be[b]) exp_mem[aq.addr][8*b +: 8] = aq.dat[8*b +: 8];
      end else if (!skip_push) begin
        exp_t e;
        e.port = ap;
        e.dat  = exp_cs ? exp_mem[aq.addr] : 32'h0;
        e.due  = cyc + 1;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/wait"}, {s1_waitrequest, s0_waitrequest}, 2'b11);
    chk({tag, "/rdv"}, {s1_readdatavalid, s0_readdatavalid}, 2'b00);
    chk({tag, "/rdata0"}, s0_readdata, 32'h0);
    chk({tag, "/rdata1"}, s1_readdata, 32'h0);
    chk({tag, "/cs_wr_clken"}, {m_chipselect, m_write, m_clken}, 3'b000);
    chk({tag, "/addr"}, m_address, 14'h0);
    chk({tag, "/oor"}, oor_count, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    reset_n = 1'b0;
    drive(rd_q(14'd5), idle_q());
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_init");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Single-master write then cross-port readback.
    step("wr5_p0", wr_q(14'd5, 32'hCAFEBABE), idle_q(), 2'b00);
    step("rd5_p1", idle_q(), rd_q(14'd5), 2'b00);
    step("wr10_p1", idle_q(), wr_q(14'd10, 32'h10101010), 2'b00);
    step("wr11_p1", idle_q(), wr_q(14'd11, 32'h11111111), 2'b00);

    // Both masters busy: grants alternate, returns overlap new grants.
    step("tie_wr", wr_q(14'd20, 32'hA0A0A0A0), wr_q(14'd21, 32'hB1B1B1B1), 2'b10);
    step("alt1", rd_q(14'd21), wr_q(14'd21, 32'hB1B1B1B1), 2'b01);
    step("alt2", rd_q(14'd21), rd_q(14'd20), 2'b10);
    step("alt3", rd_q(14'd5), rd_q(14'd20), 2'b01);
    step("alt4", rd_q(14'd5), rd_q(14'd5), 2'b10);
    step("alt5", idle_q(), rd_q(14'd5), 2'b00);

    // Port 1 lock holds port 0 off until the unlocked transfer.
    step("lk1_a", idle_q(), rd_q(14'd10, 1'b1), 2'b00);
    step("lk1_idle", rd_q(14'd20), idle_q(), 2'b01);
    step("lk1_b", rd_q(14'd20), rd_q(14'd10, 1'b1), 2'b01);
    step("lk1_rel", rd_q(14'd20), rd_q(14'd11), 2'b01);
    step("lk1_after", rd_q(14'd20), idle_q(), 2'b00);

    // Port 0 lock.
    step("lk0_a", wr_q(14'd30, 32'h30303030, 4'hF, 1'b1), idle_q(), 2'b00);
    step("lk0_idle", idle_q(), rd_q(14'd5), 2'b10);
    step("lk0_rel", rd_q(14'd30), rd_q(14'd5), 2'b10);
    step("lk0_after", idle_q(), rd_q(14'd5), 2'b00);

    // Out-of-range accesses.
    step("oor_wr", wr_q(14'd10000, 32'hDEADBEEF), idle_q(), 2'b00);
    step("oor_rd", rd_q(14'd16383), idle_q(), 2'b00);
    step("oor_idle", idle_q(), idle_q(), 2'b00);
    chk("oor_count_2", oor_count, 16'd2);

    // Partial byte-enable write.
    step("be_full", wr_q(14'd40, 32'hFFFFFFFF), idle_q(), 2'b00);
    step("be_part", wr_q(14'd40, 32'h11223344, 4'b0101), idle_q(), 2'b00);
    step("be_rd", rd_q(14'd40), idle_q(), 2'b00);
    step("be_idle", idle_q(), idle_q(), 2'b00);

    // Reset between read acceptance and its return.
    skip_push = 1'b1;
    step("rst_rd", rd_q(14'd5), idle_q(), 2'b00);
    skip_push = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset("rst_mid_a");
    @(negedge clk);
    chk_reset("rst_mid_b");
    exp_oor = 0;
    exp_last_addr = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("post_rst_idle", idle_q(), idle_q(), 2'b00);
    step("post_rst_tie", rd_q(14'd5), rd_q(14'd40), 2'b10);
    step("post_rst_p1", idle_q(), rd_q(14'd40), 2'b00);
    step("drain", idle_q(), idle_q(), 2'b00);
    step("drain2", idle_q(), idle_q(), 2'b00);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
